// File: rtl/fb_pkg.sv
// Framebuffer arbiter shared definitions.
// Holds the default address/data widths, the host write entry record
// carried through the write buffer, and the per-cycle memory grant encoding.
package fb_pkg;

    localparam int unsigned FbAddrWidth   = 13;
    localparam int unsigned FbDataWidth   = 16;
    localparam int unsigned FbStarveLimit = 16;

    // One buffered host write: target word address plus data.
    typedef struct packed {
        logic [FbAddrWidth-1:0] addr;
        logic [FbDataWidth-1:0] data;
    } fb_wr_t;

    // Owner of the memory port in the current cycle.
    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_READ,
        GRANT_WRITE
    } grant_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Two-entry synchronous write buffer.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   push        store push_entry (ignored when full)
//   push_entry  entry to store
//   pop         discard head (ignored when empty)
//   head        oldest stored entry, valid when count != 0
//   count       number of stored entries, 0..2 (registered)
// Simultaneous push and pop at count 1 keeps count at 1 and leaves the
// pushed entry behind the popped one, so acceptance order is preserved.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter type entry_t = fb_wr_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     push_entry,
    input  logic       pop,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t     slot [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;
    logic       do_push;
    logic       do_pop;

    assign do_push = push && (cnt != 2'd2);
    assign do_pop  = pop  && (cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: count gates every use of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slot[wr_ptr] <= push_entry;
        end
    end

    assign head  = slot[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer memory arbiter.
// Shares one single-port framebuffer memory between a display read stream
// (strict priority, fixed 2-cycle latency) and a buffered host write stream.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   rd_req_i, rd_addr_i     display read request pulse and address
//   rd_valid_o, rd_data_o   display read return (data holds between returns)
//   wr_valid_i, wr_ready_o  host write handshake
//   wr_addr_i, wr_data_i    host write address and data
//   mem_en_o, mem_we_o      memory strobe and direction (1 = write)
//   mem_addr_o, mem_wdata_o memory address and write data
//   mem_rdata_i             memory read data, one cycle after a read strobe
//   starve_o                sticky: a buffered write waited StarveLimit reads
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned AddrWidth   = FbAddrWidth,
    parameter int unsigned DataWidth   = FbDataWidth,
    parameter int unsigned StarveLimit = FbStarveLimit
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_req_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic                 rd_valid_o,
    output logic [DataWidth-1:0] rd_data_o,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 starve_o
);

    // Width-matched copy of fb_wr_t so non-default widths still work.
    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
    } wr_entry_t;

    localparam int unsigned          CntWidth  = $clog2(StarveLimit + 1);
    localparam logic [CntWidth-1:0]  StarveMax = CntWidth'(StarveLimit);

    wr_entry_t           push_entry;
    wr_entry_t           head;
    logic [1:0]          count;
    logic                push;
    logic                pop;
    grant_e              grant;

    logic                rd_pending;
    logic                rd_valid_q;
    logic [DataWidth-1:0] rd_data_q;

    logic [CntWidth-1:0] starve_cnt;
    logic [CntWidth-1:0] starve_cnt_next;
    logic                starve_q;

    // Ready depends only on the registered count (and reset), never on
    // this cycle's requests.
    assign wr_ready_o = !rst_i && (count != 2'd2);
    assign push       = wr_valid_i && wr_ready_o;
    assign push_entry = '{addr: wr_addr_i, data: wr_data_i};

    fb_wr_fifo #(
        .entry_t (wr_entry_t)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    // The head comes from registered storage, so a write accepted this
    // cycle cannot reach memory before the next one.
    always_comb begin
        grant = GRANT_NONE;
        if (rst_i) begin
            grant = GRANT_NONE;
        end else if (rd_req_i) begin
            grant = GRANT_READ;
        end else if (count != 2'd0) begin
            grant = GRANT_WRITE;
        end
    end

    assign pop = (grant == GRANT_WRITE);

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = head.addr;
        mem_wdata_o = head.data;
        case (grant)
            GRANT_READ: begin
                mem_en_o   = 1'b1;
                mem_addr_o = rd_addr_i;
            end
            GRANT_WRITE: begin
                mem_en_o = 1'b1;
                mem_we_o = 1'b1;
            end
            default: begin
                mem_en_o = 1'b0;
            end
        endcase
    end

    // Read return: strobe in cycle N, memory data in N+1, registered
    // output visible in N+2.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pending <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pending <= (grant == GRANT_READ);
            rd_valid_q <= rd_pending;
            if (rd_pending) begin
                rd_data_q <= mem_rdata_i;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

    // Counts reads that displaced a waiting write; any write grant or an
    // empty buffer means nothing is waiting, so the count restarts.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if ((count == 2'd0) || (grant == GRANT_WRITE)) begin
            starve_cnt_next = '0;
        end else if ((grant == GRANT_READ) && (starve_cnt != StarveMax)) begin
            starve_cnt_next = starve_cnt + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
            starve_q   <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_next;
            if (starve_cnt_next == StarveMax) begin
                starve_q <= 1'b1;
            end
        end
    end

    assign starve_o = starve_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter with a behavioural single-port memory.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [12:0] rd_addr;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        starve;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_arbiter #(
        .AddrWidth   (13),
        .DataWidth   (16),
        .StarveLimit (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .starve_o    (starve)
    );

    // Memory model: read data valid one cycle after the strobe, garbage otherwise.
    logic [15:0] mem [0:8191];

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] <= 16'h0000;
        mem[5] <= 16'h1234;
        mem[6] <= 16'h5678;
    end

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr] : 16'hDEAD;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s", name, what);
    endtask

    task automatic drive(input logic r, input logic [12:0] ra, input logic wv,
                         input logic [12:0] wa, input logic [15:0] wd);
        rd_req   = r;
        rd_addr  = ra;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle, checking outputs while held and right after release.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        drive(0, 13'h0, 0, 13'h0, 16'h0);
        @(negedge clk);
        chk({tag, ".rst_ready"}, 32'(wr_ready), 0);
        chk({tag, ".rst_en"},    32'(mem_en),   0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk({tag, ".rel_ready"},  32'(wr_ready), 1);
        chk({tag, ".rel_starve"}, 32'(starve),   0);
        chk({tag, ".rel_rvalid"}, 32'(rd_valid), 0);
        chk({tag, ".rel_rdata"},  32'(rd_data),  0);
        step();
    endtask

    typedef struct {
        logic        rd;
        logic [12:0] raddr;
        logic        wv;
        logic [12:0] waddr;
        logic [15:0] wdata;
        logic        ready;
        logic        en;
        logic        we;
        logic [12:0] maddr;
        logic [15:0] mwdata;
        logic        rvalid;
        logic [15:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [12:0] ra, input logic wv,
                                input logic [12:0] wa, input logic [15:0] wd,
                                input logic rdy, input logic en, input logic we,
                                input logic [12:0] ma, input logic [15:0] mw,
                                input logic rv, input logic [15:0] rdt);
        vec_t v;
        v.rd = r;    v.raddr = ra; v.wv = wv;  v.waddr = wa; v.wdata = wd;
        v.ready = rdy; v.en = en;  v.we = we;  v.maddr = ma; v.mwdata = mw;
        v.rvalid = rv; v.rdata = rdt;
        return v;
    endfunction

    typedef struct {
        int          due;
        logic [15:0] data;
    } rexp_t;

    vec_t        vt [15];
    rexp_t       rq [$];
    logic [28:0] wq [$];
    int          wseq;
    logic        active;
    logic [12:0] wa;
    logic [15:0] wd;

    initial begin
        // Cycle-by-cycle vectors: {rd, raddr, wv, waddr, wdata} ->
        // {ready, en, we, maddr, mwdata, rvalid, rdata}
        vt[0]  = mk(0, 13'h0,  1, 13'h12, 16'hBEEF, 1, 0, 0, 13'h0,  16'h0,    0, 16'h0);
        vt[1]  = mk(0, 13'h0,  0, 13'h0,  16'h0,    1, 1, 1, 13'h12, 16'hBEEF, 0, 16'h0);
        vt[2]  = mk(1, 13'h5,  0, 13'h0,  16'h0,    1, 1, 0, 13'h5,  16'h0,    0, 16'h0);
        vt[3]  = mk(0, 13'h0,  0, 13'h0,  16'h0,    1, 0, 0, 13'h0,  16'h0,    0, 16'h0);
        vt[4]  = mk(0, 13'h0,  0, 13'h0,  16'h0,    1, 0, 0, 13'h0,  16'h0,    1, 16'h1234);
        vt[5]  = mk(0, 13'h0,  0, 13'h0,  16'h0,    1, 0, 0, 13'h0,  16'h0,    0, 16'h1234);
        vt[6]  = mk(1, 13'h5,  1, 13'h20, 16'h1111, 1, 1, 0, 13'h5,  16'h0,    0, 16'h1234);
        vt[7]  = mk(1, 13'h6,  1, 13'h21, 16'h2222, 1, 1, 0, 13'h6,  16'h0,    0, 16'h1234);
        vt[8]  = mk(0, 13'h0,  1, 13'h22, 16'h3333, 0, 1, 1, 13'h20, 16'h1111, 1, 16'h1234);
        vt[9]  = mk(0, 13'h0,  1, 13'h22, 16'h3333, 1, 1, 1, 13'h21, 16'h2222, 1, 16'h5678);
        vt[10] = mk(0, 13'h0,  0, 13'h0,  16'h0,    1, 1, 1, 13'h22, 16'h3333, 0, 16'h5678);
        vt[11] = mk(1, 13'h21, 0, 13'h0,  16'h0,    1, 1, 0, 13'h21, 16'h0,    0, 16'h5678);
        vt[12] = mk(1, 13'h20, 0, 13'h0,  16'h0,    1, 1, 0, 13'h20, 16'h0,    0, 16'h5678);
        vt[13] = mk(0, 13'h0,  0, 13'h0,  16'h0,    1, 0, 0, 13'h0,  16'h0,    1, 16'h2222);
        vt[14] = mk(0, 13'h0,  0, 13'h0,  16'h0,    1, 0, 0, 13'h0,  16'h0,    1, 16'h1111);

        rst = 1'b1;
        drive(0, 13'h0, 0, 13'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset.rvalid", 32'(rd_valid), 0);
        chk("reset.rdata",  32'(rd_data),  0);
        chk("reset.ready",  32'(wr_ready), 0);
        chk("reset.en",     32'(mem_en),   0);
        chk("reset.we",     32'(mem_we),   0);
        chk("reset.starve", 32'(starve),   0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("release.ready", 32'(wr_ready), 1);
        step();

        // Table: single write, single read, mixed traffic, full buffer, in-order reads.
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].rd, vt[i].raddr, vt[i].wv, vt[i].waddr, vt[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d.ready", i),  32'(wr_ready), 32'(vt[i].ready));
            chk($sformatf("v%0d.en", i),     32'(mem_en),   32'(vt[i].en));
            if (vt[i].en) begin
                chk($sformatf("v%0d.we", i),   32'(mem_we),   32'(vt[i].we));
                chk($sformatf("v%0d.addr", i), 32'(mem_addr), 32'(vt[i].maddr));
                if (vt[i].we)
                    chk($sformatf("v%0d.wdata", i), 32'(mem_wdata), 32'(vt[i].mwdata));
            end
            chk($sformatf("v%0d.rvalid", i), 32'(rd_valid), 32'(vt[i].rvalid));
            chk($sformatf("v%0d.rdata", i),  32'(rd_data),  32'(vt[i].rdata));
            chk($sformatf("v%0d.starve", i), 32'(starve),   0);
            step();
        end

        // Three reads over a waiting write: one short of the limit.
        drive(0, 13'h0, 1, 13'h30, 16'hAAAA);
        @(negedge clk);
        chk("b3.ready", 32'(wr_ready), 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 13'h0, 0, 13'h0, 16'h0);
            @(negedge clk);
            chk("b3.rd_en", 32'(mem_en), 1);
            chk("b3.rd_we", 32'(mem_we), 0);
            step();
        end
        drive(0, 13'h0, 0, 13'h0, 16'h0);
        @(negedge clk);
        chk("b3.wr_en",    32'(mem_en),    1);
        chk("b3.wr_we",    32'(mem_we),    1);
        chk("b3.wr_addr",  32'(mem_addr),  32'h30);
        chk("b3.wr_data",  32'(mem_wdata), 32'hAAAA);
        chk("b3.starve",   32'(starve),    0);
        step();
        @(negedge clk);
        chk("b3.starve_after", 32'(starve), 0);
        step();

        // Three writes offered while reads hold the port for 5 cycles.
        for (int p = 0; p < 5; p++) begin
            wa = (p == 0) ? 13'h40 : (p == 1) ? 13'h41 : 13'h42;
            wd = (p == 0) ? 16'h4040 : (p == 1) ? 16'h4141 : 16'h4242;
            drive(1, 13'(p), 1, wa, wd);
            @(negedge clk);
            chk($sformatf("bp%0d.ready", p), 32'(wr_ready), (p < 2) ? 1 : 0);
            chk($sformatf("bp%0d.en", p),    32'(mem_en),   1);
            chk($sformatf("bp%0d.we", p),    32'(mem_we),   0);
            chk($sformatf("bp%0d.addr", p),  32'(mem_addr), p);
            chk($sformatf("bp%0d.starve", p), 32'(starve),  0);
            step();
        end
        drive(0, 13'h0, 1, 13'h42, 16'h4242);
        @(negedge clk);
        chk("bp5.ready",  32'(wr_ready),  0);
        chk("bp5.we",     32'(mem_we & mem_en), 1);
        chk("bp5.addr",   32'(mem_addr),  32'h40);
        chk("bp5.data",   32'(mem_wdata), 32'h4040);
        chk("bp5.starve", 32'(starve),    1);
        step();
        @(negedge clk);
        chk("bp6.ready",  32'(wr_ready),  1);
        chk("bp6.we",     32'(mem_we & mem_en), 1);
        chk("bp6.addr",   32'(mem_addr),  32'h41);
        chk("bp6.data",   32'(mem_wdata), 32'h4141);
        step();
        drive(0, 13'h0, 0, 13'h0, 16'h0);
        @(negedge clk);
        chk("bp7.we",     32'(mem_we & mem_en), 1);
        chk("bp7.addr",   32'(mem_addr),  32'h42);
        chk("bp7.data",   32'(mem_wdata), 32'h4242);
        step();
        @(negedge clk);
        chk("bp8.en",     32'(mem_en), 0);
        chk("bp8.starve", 32'(starve), 1);
        step();

        do_reset("rs1");

        // Starvation at the limit: one write held off by 4 reads.
        drive(0, 13'h0, 1, 13'h50, 16'h5050);
        @(negedge clk);
        chk("st.ready", 32'(wr_ready), 1);
        step();
        for (int q = 1; q <= 4; q++) begin
            drive(1, 13'h7, 0, 13'h0, 16'h0);
            @(negedge clk);
            chk($sformatf("st%0d.starve", q), 32'(starve), 0);
            step();
        end
        drive(0, 13'h0, 0, 13'h0, 16'h0);
        @(negedge clk);
        chk("st5.we",     32'(mem_we & mem_en), 1);
        chk("st5.addr",   32'(mem_addr),  32'h50);
        chk("st5.data",   32'(mem_wdata), 32'h5050);
        chk("st5.starve", 32'(starve),    1);
        step();
        for (int q = 6; q <= 7; q++) begin
            @(negedge clk);
            chk($sformatf("st%0d.en", q),     32'(mem_en), 0);
            chk($sformatf("st%0d.starve", q), 32'(starve), 1);
            step();
        end

        do_reset("rs2");

        // Reset with two writes buffered and a read in flight.
        drive(0, 13'h0, 1, 13'h60, 16'h6060);
        @(negedge clk);
        chk("mr0.ready", 32'(wr_ready), 1);
        step();
        drive(1, 13'h5, 1, 13'h61, 16'h6161);
        @(negedge clk);
        chk("mr1.ready", 32'(wr_ready), 1);
        chk("mr1.rd",    32'(mem_en & ~mem_we), 1);
        step();
        rst = 1'b1;
        drive(0, 13'h0, 0, 13'h0, 16'h0);
        @(negedge clk);
        chk("mr2.ready", 32'(wr_ready), 0);
        chk("mr2.en",    32'(mem_en),   0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mr3.ready",  32'(wr_ready), 1);
        chk("mr3.rdata",  32'(rd_data),  0);
        step();
        for (int r = 3; r < 10; r++) begin
            if (r > 3) @(negedge clk);
            else       ;
            chk($sformatf("mr%0d.en", r),     32'(mem_en),   0);
            chk($sformatf("mr%0d.rvalid", r), 32'(rd_valid), 0);
            step();
        end

        // Soak: read every 10th cycle, continuous host writes, then drain.
        wseq = 0;
        for (int k = 0; k < 1012; k++) begin
            active = (k < 1000);
            drive(active && (k % 10 == 0), 13'(32'h100 + (k / 10) % 32),
                  active, 13'(32'h100 + wseq % 32), 16'(wseq * 7 + 3));
            @(negedge clk);
            if (mem_en && mem_we) begin
                if (wq.size() == 0) begin
                    fail("soak.wr_order", "memory write with nothing accepted, required none");
                end else begin
                    chk("soak.wr_order", 32'({mem_addr, mem_wdata}), 32'(wq[0]));
                    void'(wq.pop_front());
                end
            end
            if (wr_valid && wr_ready) begin
                wq.push_back({wr_addr, wr_data});
                wseq++;
            end
            if (rd_req) begin
                chk("soak.rd_strobe", 32'(mem_en & ~mem_we), 1);
                chk("soak.rd_addr",   32'(mem_addr), 32'(rd_addr));
                rq.push_back('{due: k + 2, data: mem[rd_addr]});
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    fail("soak.rd_valid", "unexpected rd_valid, required 0");
                end else begin
                    chk("soak.rd_lat",  rq[0].due, k);
                    chk("soak.rd_data", 32'(rd_data), 32'(rq[0].data));
                    void'(rq.pop_front());
                end
            end else if (rq.size() != 0 && rq[0].due <= k) begin
                fail("soak.rd_missing", "rd_valid 0, required 1");
                void'(rq.pop_front());
            end
            step();
        end
        chk("soak.wq_empty",  wq.size(), 0);
        chk("soak.rq_empty",  rq.size(), 0);
        chk("soak.accepted",  32'(wseq >= 850), 1);
        chk("soak.starve",    32'(starve), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
